// File: rtl/cardinal_pkg.sv
// Shared constants for the cardinal mesh NIC: register map, header bit
// positions and default widths.
package cardinal_pkg;

    localparam int unsigned DATA_W_DEFAULT = 64;
    localparam int unsigned ADDR_W_DEFAULT = 2;

    // Processor register map
    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    // Packet header bit positions (64-bit layout)
    localparam int unsigned VC_BIT    = 63;
    localparam int unsigned DX_BIT    = 62;
    localparam int unsigned DY_BIT    = 61;
    localparam int unsigned HX_MSB    = 55;
    localparam int unsigned HX_LSB    = 52;
    localparam int unsigned HY_MSB    = 51;
    localparam int unsigned HY_LSB    = 48;
    localparam int unsigned SRCX_MSB  = 47;
    localparam int unsigned SRCX_LSB  = 40;
    localparam int unsigned SRCY_MSB  = 39;
    localparam int unsigned SRCY_LSB  = 32;

endpackage

// File: rtl/nic_chan_buf.sv
// Single-entry channel buffer: data register plus full flag.
// Ports: clk, reset (async active-low), i_load (capture i_data, set full),
//        i_clear (drop full), i_data, o_data, o_full.
// A load takes priority over a clear so a packet arriving into an empty
// buffer is never lost.
module nic_chan_buf #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full
);

    logic [W-1:0] r_data;
    logic         r_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/cardinal_nic.sv
// Network interface between a processing element and its router local port.
// Ports: clk, reset (async active-low);
//   processor side: addr, d_in, d_out (registered), nicEn, nicWrEn;
//   network side:   net_si/net_ri/net_di (ejection), net_so/net_ro/net_do
//                   (injection), net_polarity (router VC phase).
module cardinal_nic
    import cardinal_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    input  logic              net_ro,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);

    logic              w_rd;
    logic              w_wr;
    logic              w_out_wr;
    logic              w_out_load;
    logic              w_in_load;
    logic              w_in_rd;
    logic              w_stat_rd;
    logic              w_ovf_set;
    logic              w_send;
    logic              w_in_full;
    logic              w_out_full;
    logic [DATA_W-1:0] w_in_buf;
    logic [DATA_W-1:0] w_out_buf;
    logic [DATA_W-1:0] w_rd_data;
    logic              r_ovf;
    logic [DATA_W-1:0] r_d_out;

    // Access decode
    assign w_rd      = nicEn & ~nicWrEn;
    assign w_wr      = nicEn & nicWrEn;
    assign w_out_wr  = w_wr & (addr == ADDR_W'(ADDR_OUT_BUF));
    assign w_in_rd   = w_rd & (addr == ADDR_W'(ADDR_IN_BUF));
    assign w_stat_rd = w_rd & (addr == ADDR_W'(ADDR_IN_STAT));

    // Injection only when the packet's VC matches the router's current phase
    assign w_send     = w_out_full & net_ro & (w_out_buf[VC_BIT] == net_polarity);
    // A write racing a send still sees the buffer as full and is dropped
    assign w_out_load = w_out_wr & ~w_out_full;
    assign w_in_load  = net_si & ~w_in_full;
    assign w_ovf_set  = (w_out_wr & w_out_full) | (net_si & w_in_full);

    nic_chan_buf #(.W(DATA_W)) u_in_buf (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_in_load),
        .i_clear (w_in_rd),
        .i_data  (net_di),
        .o_data  (w_in_buf),
        .o_full  (w_in_full)
    );

    nic_chan_buf #(.W(DATA_W)) u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_out_load),
        .i_clear (w_send),
        .i_data  (d_in),
        .o_data  (w_out_buf),
        .o_full  (w_out_full)
    );

    // Sticky overflow; a new overflow wins over a same-edge status read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_stat_rd) begin
            r_ovf <= 1'b0;
        end
    end

    // Read data select
    always_comb begin
        w_rd_data = '0;
        case (addr)
            ADDR_W'(ADDR_IN_BUF):   w_rd_data = w_in_buf;
            ADDR_W'(ADDR_IN_STAT):  w_rd_data = DATA_W'({r_ovf, w_in_full});
            ADDR_W'(ADDR_OUT_STAT): w_rd_data = DATA_W'(w_out_full);
            default:                w_rd_data = '0;
        endcase
    end

    // Registered read port, holds between reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_out <= '0;
        end else if (w_rd) begin
            r_d_out <= w_rd_data;
        end
    end

    assign d_out  = r_d_out;
    assign net_ri = ~w_in_full;
    assign net_so = w_send;
    assign net_do = w_out_buf;

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed scenarios with literal
// expectations plus a randomized phase, all checked against a transaction
// level model of the NIC's register file and channel buffers.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr = 2'b00;
    logic [63:0] d_in = '0;
    logic [63:0] d_out;
    logic        nicEn = 1'b0;
    logic        nicWrEn = 1'b0;
    logic        net_si = 1'b0;
    logic        net_ri;
    logic [63:0] net_di = '0;
    logic        net_so;
    logic        net_ro = 1'b0;
    logic [63:0] net_do;
    logic        net_polarity = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [63:0] m_in_buf = '0;
    logic        m_in_full = 1'b0;
    logic [63:0] m_out_buf = '0;
    logic        m_out_full = 1'b0;
    logic        m_ovf = 1'b0;
    logic [63:0] m_dout = '0;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what each register and buffer holds after every clock edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_in_buf = '0; m_in_full = 1'b0; m_out_buf = '0;
            m_out_full = 1'b0; m_ovf = 1'b0; m_dout = '0;
        end else begin
            bit rd, wr, sent, in_was_full, out_was_full;
            rd = nicEn && !nicWrEn;
            wr = nicEn && nicWrEn;
            in_was_full = m_in_full;
            out_was_full = m_out_full;
            sent = m_out_full && net_ro && (m_out_buf[63] == net_polarity);
            if (rd) begin
                case (addr)
                    2'd0: m_dout = m_in_buf;
                    2'd1: m_dout = {62'd0, m_ovf, m_in_full};
                    2'd2: m_dout = 64'd0;
                    default: m_dout = {63'd0, m_out_full};
                endcase
            end
            if (rd && addr == 2'd1) m_ovf = 1'b0;
            if (wr && addr == 2'd2 && out_was_full) m_ovf = 1'b1;
            if (net_si && in_was_full) m_ovf = 1'b1;
            if (sent) m_out_full = 1'b0;
            if (wr && addr == 2'd2 && !out_was_full) begin
                m_out_buf = d_in;
                m_out_full = 1'b1;
            end
            if (net_si && !in_was_full) begin
                m_in_buf = net_di;
                m_in_full = 1'b1;
            end else if (rd && addr == 2'd0) begin
                m_in_full = 1'b0;
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("d_out", d_out, m_dout);
            check("net_ri", 64'(net_ri), 64'(!m_in_full));
            check("net_do", net_do, m_out_buf);
            check("net_so", 64'(net_so),
                  64'(m_out_full && net_ro && (m_out_buf[63] == net_polarity)));
        end
    end

    // One clock; returns just after the falling edge with outputs settled
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic reg_read(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        tick();
        nicEn = 1'b0;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    localparam logic [63:0] V1  = 64'h0123_4567_DEAD_BEEF;
    localparam logic [63:0] V2  = 64'h0A0A_0000_1111_2222;
    localparam logic [63:0] V3  = 64'h8000_0000_3333_3333;
    localparam logic [63:0] V4  = 64'h0000_0000_4444_4444;
    localparam logic [63:0] PKT = 64'hC0A5_0000_0102_BEEF;

    initial begin
        // Reset and idle
        repeat (3) tick();
        reset = 1'b1;
        chk_en = 1'b1;
        tick();
        check("rst_dout", d_out, 64'd0);
        check("rst_so", 64'(net_so), 64'd0);
        check("rst_ri", 64'(net_ri), 64'd1);
        reg_read(2'b01);
        check("rst_stat", d_out, 64'd0);

        // Polarity-gated send
        net_ro = 1'b1; net_polarity = 1'b1;
        reg_write(2'b10, V1);
        check("pol_block", 64'(net_so), 64'd0);
        tick();
        check("pol_block2", 64'(net_so), 64'd0);
        net_polarity = 1'b0;
        #1;
        check("pol_send", 64'(net_so), 64'd1);
        check("pol_do", net_do, V1);
        tick();
        check("pol_once", 64'(net_so), 64'd0);
        reg_read(2'b11);
        check("pol_stat", d_out, 64'd0);

        // Backpressure
        net_ro = 1'b0;
        reg_write(2'b10, V2);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 64'(net_so), 64'd0);
            tick();
        end
        reg_read(2'b11);
        check("bp_stat", d_out, 64'd1);
        net_ro = 1'b1;
        #1;
        check("bp_send", 64'(net_so), 64'd1);
        tick();
        check("bp_once", 64'(net_so), 64'd0);

        // Overflow on write-while-full
        net_ro = 1'b0;
        reg_write(2'b10, V3);
        reg_write(2'b10, V4);
        check("ovf_do", net_do, V3);
        reg_read(2'b01);
        check("ovf_stat", d_out, 64'd2);
        reg_read(2'b01);
        check("ovf_clr", d_out, 64'd0);
        reg_read(2'b10);
        check("wo_read", d_out, 64'd0);
        net_ro = 1'b1; net_polarity = 1'b1;
        tick();
        check("ovf_drain", 64'(net_so), 64'd0);

        // Ejection
        net_si = 1'b1; net_di = PKT;
        tick();
        net_si = 1'b0;
        check("ej_ri", 64'(net_ri), 64'd0);
        reg_read(2'b01);
        check("ej_stat", d_out, 64'd1);
        reg_read(2'b00);
        check("ej_data", d_out, PKT);
        check("ej_ri_free", 64'(net_ri), 64'd1);

        // Asynchronous reset with both buffers full
        net_ro = 1'b0; net_polarity = 1'b0;
        reg_write(2'b10, V1);
        net_si = 1'b1; net_di = PKT;
        tick();
        net_si = 1'b0;
        net_ro = 1'b1;
        #1;
        check("ar_pre_so", 64'(net_so), 64'd1);
        check("ar_pre_ri", 64'(net_ri), 64'd0);
        #1 reset = 1'b0;
        #1;
        check("ar_so", 64'(net_so), 64'd0);
        check("ar_ri", 64'(net_ri), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        check("ar_nosend", 64'(net_so), 64'd0);
        reg_read(2'b00);
        check("ar_inbuf", d_out, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nicEn        = ($urandom_range(0, 1) == 1);
            nicWrEn      = ($urandom_range(0, 1) == 1);
            addr         = 2'($urandom_range(0, 3));
            d_in         = {$urandom, $urandom};
            net_si       = ($urandom_range(0, 3) == 0);
            net_di       = {$urandom, $urandom};
            net_ro       = ($urandom_range(0, 3) != 0);
            net_polarity = ($urandom_range(0, 1) == 1);
            tick();
        end
        nicEn = 1'b0; net_si = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
